// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues in-order imem reads under a credit limit,
// and buffers returned words with their PC for decode. Redirects flush and discard in-flight reads.
module instruction_fetch #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_INC   = 4,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] instr_pc
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_e;

  state_e                        state_q, state_d;
  logic [ADDR_W-1:0]             pc_q, pc_d;
  logic [CW-1:0]                 outst_q, outst_d;
  logic [CW-1:0]                 disc_q, disc_d;
  logic [CW-1:0]                 count_q, count_d;
  logic [PW-1:0]                 wr_q, wr_d;
  logic [PW-1:0]                 rd_q, rd_d;
  logic [DEPTH-1:0][31:0]        bi_q, bi_d;
  logic [DEPTH-1:0][ADDR_W-1:0]  bp_q, bp_d;

  logic              grant, rsp, push, pop;
  logic [CW:0]       credits;
  logic [ADDR_W-1:0] head_pc;

  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid & instr_ready;
  assign rsp         = imem_rvalid & (outst_q != '0);
  assign push        = rsp & (disc_q == '0) & ~redirect;

  // A pop this cycle frees a slot, which keeps 1 instr/cycle streaming with DEPTH=2.
  assign credits   = {1'b0, outst_q} + {1'b0, count_q} - (CW+1)'(pop);
  assign imem_req  = (state_q == RUN) & ~redirect & (credits < (CW+1)'(DEPTH));
  assign imem_addr = pc_q;
  assign grant     = imem_req & imem_gnt;

  // Grants are sequential from pc, and every outstanding read in RUN post-dates the
  // last redirect, so the oldest pending PC is pc minus the outstanding span.
  assign head_pc = pc_q - ADDR_W'(outst_q) * ADDR_W'(PC_INC);

  assign instruction = instr_valid ? bi_q[rd_q] : '0;
  assign instr_pc    = instr_valid ? bp_q[rd_q] : '0;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    disc_d  = disc_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    bi_d    = bi_q;
    bp_d    = bp_q;
    outst_d = outst_q + CW'(grant) - CW'(rsp);
    count_d = count_q + CW'(push) - CW'(pop);

    if (grant) pc_d = pc_q + ADDR_W'(PC_INC);
    if (push) begin
      bi_d[wr_q] = imem_rdata;
      bp_d[wr_q] = head_pc;
      wr_d       = wr_q + PW'(1);
    end
    if (pop) rd_d = rd_q + PW'(1);
    if (rsp && disc_q != '0) disc_d = disc_q - CW'(1);

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      FLUSH:   if (disc_d == '0) state_d = RUN;
      default: state_d = BOOT;
    endcase

    // Everything still in flight after this cycle belongs to the old stream.
    if (redirect) begin
      pc_d    = redirect_pc;
      count_d = '0;
      wr_d    = '0;
      rd_d    = '0;
      disc_d  = outst_d;
      state_d = (outst_d != '0) ? FLUSH : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      outst_q <= '0;
      disc_q  <= '0;
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      bi_q    <= '0;
      bp_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      disc_q  <= disc_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      bi_q    <= bi_d;
      bp_q    <= bp_d;
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch: an in-order memory model with variable latency
// and an expected-PC stream model check every instruction handed to decode.
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instruction;
  logic [15:0] instr_pc;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc)
  );

  typedef struct { logic [15:0] addr; int due; } rd_t;
  rd_t         mq[$];
  int          cyc = 0, last_due = 0;
  int          n_chk = 0, n_err = 0;
  int          npops = 0;
  logic [15:0] exp_pc = '0;
  logic        redir_prev = 1'b0, force_redir = 1'b0;
  logic [15:0] force_pc = '0;
  logic        s_req, s_gnt, s_vld;
  logic [15:0] s_addr;
  logic [15:0] pop_pc[$];
  int          pop_cyc[$];

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {~a, a ^ 16'h5A5A};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive inputs at negedge, sample and book-keep what the next posedge commits.
  task automatic step(input int gp, input int rp, input int dp, input int llo, input int lhi);
    int d;
    @(negedge clk);
    if (redir_prev) chk("flush_vld", instr_valid, 0);
    redirect    = force_redir || ($urandom_range(99) < dp);
    redirect_pc = force_redir ? force_pc : (16'($urandom) & 16'hFFFC);
    instr_ready = !redirect && ($urandom_range(99) < rp);
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    imem_gnt = ($urandom_range(99) < gp);
    s_req = imem_req; s_gnt = imem_gnt; s_addr = imem_addr; s_vld = instr_valid;
    if (imem_req && imem_gnt) begin
      d = cyc + 1 + $urandom_range(lhi, llo);
      if (d < last_due) d = last_due;
      last_due = d;
      mq.push_back('{imem_addr, d});
    end
    if (instr_valid && instr_ready) begin
      chk("pc", instr_pc, exp_pc);
      chk("data", instruction, mem_word(exp_pc));
      pop_pc.push_back(instr_pc);
      pop_cyc.push_back(cyc);
      npops++;
      exp_pc = exp_pc + 16'd4;
    end
    if (redirect) exp_pc = redirect_pc;
    redir_prev = redirect;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0;
    mq.delete();
    redir_prev = 1'b0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_vld", instr_valid, 0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_instr", instruction, 0);
    chk("rst_ipc", instr_pc, 0);
    cyc++;
    @(negedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    // stray response with nothing outstanding must be ignored
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEADBEEF;
    instr_ready = 1'b1;
    #1;
    chk("boot_req", imem_req, 0);
    chk("boot_vld", instr_valid, 0);
    exp_pc   = 16'h0000;
    last_due = cyc;
    cyc++;
  endtask

  initial begin
    int g0, n0;
    logic [15:0] a0;
    do_reset();
    repeat (40) step(70, 30, 0, 0, 3);

    // reset mid-fetch, then boot timing and streaming
    do_reset();
    pop_cyc.delete(); pop_pc.delete();
    step(100, 100, 0, 0, 0);
    chk("t1_req", s_req, 1);
    chk("t1_addr", s_addr, 16'h0000);
    chk("stray_vld", s_vld, 0);
    g0 = cyc - 1;
    repeat (7) step(100, 100, 0, 0, 0);
    chk("t2_cnt", 32'(pop_cyc.size() >= 4), 1);
    if (pop_cyc.size() >= 4) begin
      chk("t2_lat", pop_cyc[0], g0 + 2);
      for (int i = 1; i < 4; i++) begin
        chk("t2_b2b", pop_cyc[i], pop_cyc[0] + i);
        chk("t2_pc", pop_pc[i], 16'(4 * i));
      end
    end

    // backpressure
    n0 = npops;
    repeat (6) step(100, 0, 0, 0, 0);
    chk("t3_req", s_req, 0);
    chk("t3_vld", s_vld, 1);
    repeat (6) step(100, 100, 0, 0, 0);
    chk("t3_drain", 32'(npops - n0 >= 4), 1);

    // redirect with two reads in flight
    repeat (4) step(0, 100, 0, 0, 0);
    step(100, 100, 0, 3, 3);
    chk("t4_g1", s_req & s_gnt, 1);
    step(100, 100, 0, 3, 3);
    chk("t4_g2", s_req & s_gnt, 1);
    force_redir = 1'b1; force_pc = 16'h0040;
    step(0, 100, 0, 0, 0);
    force_redir = 1'b0;
    pop_pc.delete();
    repeat (10) step(100, 100, 0, 0, 0);
    chk("t4_cnt", 32'(pop_pc.size() > 0), 1);
    if (pop_pc.size() > 0) chk("t4_pc", pop_pc[0], 16'h0040);

    // PC wrap
    force_redir = 1'b1; force_pc = 16'hFFFC;
    step(100, 100, 0, 0, 0);
    force_redir = 1'b0;
    pop_pc.delete();
    repeat (8) step(100, 100, 0, 0, 0);
    chk("t5_cnt", 32'(pop_pc.size() >= 2), 1);
    if (pop_pc.size() >= 2) begin
      chk("t5_pc0", pop_pc[0], 16'hFFFC);
      chk("t5_pc1", pop_pc[1], 16'h0000);
    end

    // grant withheld: request and address hold
    repeat (4) step(0, 100, 0, 0, 0);
    chk("t6_req0", s_req, 1);
    a0 = s_addr;
    repeat (3) begin
      step(0, 100, 0, 0, 0);
      chk("t6_req", s_req, 1);
      chk("t6_addr", s_addr, a0);
    end
    step(100, 100, 0, 0, 0);
    chk("t6_acc", s_req & s_gnt, 1);
    chk("t6_acc_addr", s_addr, a0);

    // random traffic with redirects
    repeat (1500) step(70, 70, 4, 0, 3);
    repeat (10) step(0, 100, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
